// File: rtl/xadac_obi_mem_sbr.sv
// xadac_obi_mem_sbr: OBI subordinate scratchpad memory with byte enables
// and in-order, fall-through buffered responses for up to RspDepth outstanding requests.
module xadac_obi_mem_sbr #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o
);
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned PtrW     = RspDepth > 1 ? $clog2(RspDepth) : 1;
    localparam int unsigned CntW     = $clog2(RspDepth + 1);

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [IdxW-1:0]      idx;
    logic                 acc, hs, err, push, pop, head_v;
    logic                 gnt_q;
    logic [CntW-1:0]      cnt_q, cnt_d, fc_q, fc_d;
    logic [PtrW-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic                 st_v_q, st_we_q, st_err_q;
    logic [IdWidth-1:0]   st_id_q;
    logic [DataWidth-1:0] st_rd_q, st_data;
    logic [DataWidth-1:0] fd_q [RspDepth];
    logic [IdWidth-1:0]   fid_q [RspDepth];
    logic [RspDepth-1:0]  ferr_q;

    assign idx     = addr_i[IdxW+3:4];
    assign err     = (addr_i[3:0] != 4'd0) || (addr_i[AddrWidth-1:IdxW+4] != '0);
    assign acc     = req_i && gnt_q;
    assign gnt_o   = gnt_q;
    assign head_v  = fc_q != '0;
    assign st_data = (st_we_q || st_err_q) ? '0 : st_rd_q;

    // Queued responses are older than the in-flight stage, so they win the outputs.
    assign rvalid_o = head_v || st_v_q;
    assign rdata_o  = head_v ? fd_q[rp_q] : st_data;
    assign rid_o    = head_v ? fid_q[rp_q] : st_id_q;
    assign err_o    = head_v ? ferr_q[rp_q] : st_err_q;

    assign hs   = rvalid_o && rready_i;
    assign pop  = hs && head_v;
    // The stage is parked in the queue unless it is consumed directly this cycle.
    assign push = st_v_q && !(hs && !head_v);

    always_comb begin
        cnt_d = cnt_q + CntW'(acc) - CntW'(hs);
        fc_d  = fc_q + CntW'(push) - CntW'(pop);
        wp_d  = push ? (wp_q == PtrW'(RspDepth - 1) ? '0 : wp_q + PtrW'(1)) : wp_q;
        rp_d  = pop ? (rp_q == PtrW'(RspDepth - 1) ? '0 : rp_q + PtrW'(1)) : rp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            fc_q     <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            st_v_q   <= 1'b0;
            st_we_q  <= 1'b0;
            st_err_q <= 1'b0;
            st_id_q  <= '0;
            st_rd_q  <= '0;
        end else begin
            gnt_q  <= cnt_d < CntW'(RspDepth);
            cnt_q  <= cnt_d;
            fc_q   <= fc_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            st_v_q <= acc;
            if (acc) begin
                st_we_q  <= we_i;
                st_err_q <= err;
                st_id_q  <= aid_i;
                st_rd_q  <= mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fd_q[wp_q]   <= st_data;
            fid_q[wp_q]  <= st_id_q;
            ferr_q[wp_q] <= st_err_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc && we_i && !err) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (be_i[i]) mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end
endmodule
